// File: rtl/conv3x3_multich_engine.sv
// Streaming multi-channel 3x3 valid convolution: loadable signed weights and bias,
// per-channel line buffers, full-precision channel sum, optional ReLU, frame tracking.
module conv3x3_multich_engine #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 64,
   parameter int IMAGE_WIDTH  = 222,
   parameter int IMAGE_HEIGHT = 222,
   parameter int ACC_WIDTH    = 2*DATA_WIDTH+1+$clog2(9*NUM_CHANNELS)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               load_weight,
   input  logic [DATA_WIDTH-1:0]              weight_in,
   input  logic                               weight_valid,
   output logic                               weights_ready,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] pixels_in,
   input  logic                               pixel_valid,
   input  logic                               relu_en,
   output logic [ACC_WIDTH-1:0]               conv_out,
   output logic                               conv_out_valid,
   output logic                               conv_out_last,
   output logic                               frame_done
);
   localparam int NUM_TAPS = 9*NUM_CHANNELS;
   localparam int PROD_W   = 2*DATA_WIDTH+1;
   localparam int IDX_W    = $clog2(NUM_TAPS+2);
   localparam int COL_W    = $clog2(IMAGE_WIDTH);
   localparam int ROW_W    = $clog2(IMAGE_HEIGHT);
   localparam logic [IDX_W-1:0] BIAS_IDX = IDX_W'(NUM_TAPS);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH-1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT-1);

   logic signed [DATA_WIDTH-1:0] weight_r [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] bias_r;
   logic [IDX_W-1:0]             idx_r;
   logic [IDX_W-1:0]             idx_eff_s;
   logic                         load_d_r;
   logic                         load_rise_s;
   logic                         wr_en_s;
   logic                         weights_ready_r;

   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;
   logic             accept_s;
   logic             col_last_s;
   logic             row_last_s;
   logic             win_ok_s;
   logic             abort_s;

   logic [DATA_WIDTH-1:0] lb0_r [NUM_CHANNELS][IMAGE_WIDTH];
   logic [DATA_WIDTH-1:0] lb1_r [NUM_CHANNELS][IMAGE_WIDTH];
   logic [DATA_WIDTH-1:0] win_r [NUM_CHANNELS][3][2];
   logic [DATA_WIDTH-1:0] col_new_s [NUM_CHANNELS][3];
   logic [DATA_WIDTH-1:0] tap_s [NUM_CHANNELS][9];

   logic signed [PROD_W-1:0]    prod_s [NUM_TAPS];
   logic signed [PROD_W-1:0]    prod_r [NUM_TAPS];
   logic signed [ACC_WIDTH-1:0] sum_s;
   logic signed [ACC_WIDTH-1:0] sum_r;
   logic signed [ACC_WIDTH-1:0] out_r;
   logic valid_a_r, last_a_r, valid_b_r, last_b_r, valid_o_r, last_o_r;

   // Control decode: load edge, write enable, pixel accept and window position flags
   always_comb begin
      load_rise_s = load_weight & ~load_d_r;
      if (load_rise_s) begin
         idx_eff_s = '0;
      end else begin
         idx_eff_s = idx_r;
      end
      wr_en_s    = load_weight & weight_valid & (idx_eff_s <= BIAS_IDX);
      accept_s   = pixel_valid & ~load_weight & weights_ready_r & ~rst;
      col_last_s = (col_r == COL_LAST);
      row_last_s = (row_r == ROW_LAST);
      win_ok_s   = (col_r >= COL_W'(2)) & (row_r >= ROW_W'(2));
      // Loading only aborts when a frame is actually in progress; a completed frame drains.
      abort_s    = load_weight & ((col_r != '0) | (row_r != '0));
   end

   // Weight/bias store with saturating word index
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            weight_r[i] <= '0;
         end
         bias_r          <= '0;
         idx_r           <= '0;
         load_d_r        <= 1'b0;
         weights_ready_r <= 1'b0;
      end else begin
         load_d_r <= load_weight;
         if (load_rise_s) begin
            idx_r           <= '0;
            weights_ready_r <= 1'b0;
         end
         if (wr_en_s) begin
            if (idx_eff_s == BIAS_IDX) begin
               bias_r          <= weight_in;
               weights_ready_r <= 1'b1;
            end else begin
               weight_r[idx_eff_s] <= weight_in;
            end
            idx_r <= idx_eff_s + IDX_W'(1);
         end
      end
   end

   // Column/row position of the next pixel in the frame
   always_ff @(posedge clk) begin
      if (rst || load_weight) begin
         col_r <= '0;
         row_r <= '0;
      end else if (accept_s) begin
         if (col_last_s) begin
            col_r <= '0;
            if (row_last_s) begin
               row_r <= '0;
            end else begin
               row_r <= row_r + ROW_W'(1);
            end
         end else begin
            col_r <= col_r + COL_W'(1);
         end
      end
   end

   // Taps of the window completed by the current pixel, and their products
   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         col_new_s[c][0] = lb1_r[c][col_r];
         col_new_s[c][1] = lb0_r[c][col_r];
         col_new_s[c][2] = pixels_in[c*DATA_WIDTH +: DATA_WIDTH];
         for (int r = 0; r < 3; r++) begin
            tap_s[c][r*3+0] = win_r[c][r][0];
            tap_s[c][r*3+1] = win_r[c][r][1];
            tap_s[c][r*3+2] = col_new_s[c][r];
         end
         for (int t = 0; t < 9; t++) begin
            prod_s[c*9+t] = $signed({{DATA_WIDTH{1'b0}}, 1'b0, tap_s[c][t]})
                          * $signed({{(DATA_WIDTH+1){weight_r[c*9+t][DATA_WIDTH-1]}}, weight_r[c*9+t]});
         end
      end
   end

   // Line buffers and the two stored window columns; contents need no reset
   always_ff @(posedge clk) begin
      if (accept_s) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            lb1_r[c][col_r] <= lb0_r[c][col_r];
            lb0_r[c][col_r] <= pixels_in[c*DATA_WIDTH +: DATA_WIDTH];
            for (int r = 0; r < 3; r++) begin
               win_r[c][r][0] <= win_r[c][r][1];
               win_r[c][r][1] <= col_new_s[c][r];
            end
         end
      end
   end

   // Full-width sum of all products plus sign-extended bias
   always_comb begin
      sum_s = {{(ACC_WIDTH-DATA_WIDTH){bias_r[DATA_WIDTH-1]}}, bias_r};
      for (int i = 0; i < NUM_TAPS; i++) begin
         sum_s = sum_s + {{(ACC_WIDTH-PROD_W){prod_r[i][PROD_W-1]}}, prod_r[i]};
      end
   end

   // Valid/last pipeline alongside the three datapath stages
   always_ff @(posedge clk) begin
      if (rst || abort_s) begin
         valid_a_r <= 1'b0;
         last_a_r  <= 1'b0;
         valid_b_r <= 1'b0;
         last_b_r  <= 1'b0;
         valid_o_r <= 1'b0;
         last_o_r  <= 1'b0;
      end else begin
         valid_a_r <= accept_s & win_ok_s;
         last_a_r  <= accept_s & win_ok_s & col_last_s & row_last_s;
         valid_b_r <= valid_a_r;
         last_b_r  <= last_a_r;
         valid_o_r <= valid_b_r;
         last_o_r  <= last_b_r;
      end
   end

   // Datapath registers: products, sum, ReLU output
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            prod_r[i] <= '0;
         end
         sum_r <= '0;
         out_r <= '0;
      end else begin
         if (accept_s & win_ok_s) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
               prod_r[i] <= prod_s[i];
            end
         end
         if (valid_a_r) begin
            sum_r <= sum_s;
         end
         if (valid_b_r) begin
            if (relu_en && sum_r[ACC_WIDTH-1]) begin
               out_r <= '0;
            end else begin
               out_r <= sum_r;
            end
         end
      end
   end

   assign weights_ready  = weights_ready_r;
   assign conv_out       = out_r;
   assign conv_out_valid = valid_o_r & ~abort_s;
   assign conv_out_last  = last_o_r & ~abort_s;
   assign frame_done     = accept_s & col_last_s & row_last_s;

endmodule

// File: tb/tb_conv3x3_multich_engine.sv
// Scoreboard bench for conv3x3_multich_engine: driver pushes expected results from a
// direct array-based convolution model; a negedge monitor pops and compares.
module tb_conv3x3_multich_engine;
   localparam int DW = 8;
   localparam int NC = 2;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int AW = 22;
   localparam int NT = NC*9;

   logic           clk = 1'b0;
   logic           rst;
   logic           load_weight;
   logic [DW-1:0]  weight_in;
   logic           weight_valid;
   logic           weights_ready;
   logic [NC*DW-1:0] pixels_in;
   logic           pixel_valid;
   logic           relu_en;
   logic [AW-1:0]  conv_out;
   logic           conv_out_valid;
   logic           conv_out_last;
   logic           frame_done;

   conv3x3_multich_engine #(
      .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ACC_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst), .load_weight(load_weight), .weight_in(weight_in),
      .weight_valid(weight_valid), .weights_ready(weights_ready), .pixels_in(pixels_in),
      .pixel_valid(pixel_valid), .relu_en(relu_en), .conv_out(conv_out),
      .conv_out_valid(conv_out_valid), .conv_out_last(conv_out_last), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int val;
      bit last;
      int cyc;
   } exp_t;
   exp_t exp_q[$];

   // reference model state
   int m_w [NT];
   int m_b = 0;
   int m_idx = 0;
   bit m_ready = 1'b0;
   bit m_lw_prev = 1'b0;
   bit m_prev_rst = 1'b0;
   int m_row = 0;
   int m_col = 0;
   int m_img [NC][H][W];
   bit fd_exp = 1'b0;
   bit chk_zero = 1'b0;
   bit tb_done = 1'b0;
   int ld_w [NT];
   int ld_b = 0;

   int checks = 0;
   int errors = 0;

   function automatic logic [15:0] pk(input int a, input int b);
      logic [7:0] x;
      logic [7:0] y;
      x = a[7:0];
      y = b[7:0];
      return {y, x};
   endfunction

   task automatic chk(input string n, input longint a, input longint x);
      checks++;
      if (a != x) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, x, cyc);
      end
   endtask

   // One clock of stimulus; the model advances after the monitor has sampled this cycle.
   task automatic step(input bit r, input bit lw, input bit wv, input logic [7:0] wi,
                       input bit pv, input logic [15:0] px);
      bit acc;
      int s;
      exp_t ne;
      rst = r; load_weight = lw; weight_valid = wv; weight_in = wi;
      pixel_valid = pv; pixels_in = px;
      acc = pv && !lw && m_ready && !r;
      fd_exp = acc && (m_row == H-1) && (m_col == W-1);
      chk_zero = m_prev_rst;
      if (lw && !r && (m_row != 0 || m_col != 0)) exp_q.delete();
      @(negedge clk); #1;
      m_prev_rst = r;
      if (r) begin
         for (int i = 0; i < NT; i++) m_w[i] = 0;
         m_b = 0; m_idx = 0; m_ready = 1'b0; m_lw_prev = 1'b0;
         m_row = 0; m_col = 0;
         exp_q.delete();
      end else begin
         if (lw) begin
            if (!m_lw_prev) begin
               m_idx = 0;
               m_ready = 1'b0;
            end
            m_row = 0; m_col = 0;
            if (wv && m_idx <= NT) begin
               if (m_idx == NT) begin
                  m_b = $signed(wi);
                  m_ready = 1'b1;
               end else begin
                  m_w[m_idx] = $signed(wi);
               end
               m_idx++;
            end
         end
         if (acc) begin
            for (int c = 0; c < NC; c++) m_img[c][m_row][m_col] = int'(px[c*8 +: 8]);
            if (m_row >= 2 && m_col >= 2) begin
               s = m_b;
               for (int c = 0; c < NC; c++)
                  for (int rr = 0; rr < 3; rr++)
                     for (int k = 0; k < 3; k++)
                        s += m_img[c][m_row-2+rr][m_col-2+k] * m_w[c*9+rr*3+k];
               if (relu_en && s < 0) s = 0;
               ne.val = s;
               ne.last = (m_row == H-1) && (m_col == W-1);
               ne.cyc = cyc + 3;
               exp_q.push_back(ne);
            end
            if (m_col == W-1) begin
               m_col = 0;
               m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
               m_col++;
            end
         end
         m_lw_prev = lw;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 16'h0000);
   endtask

   task automatic set_w_all(input int w, input int b);
      for (int i = 0; i < NT; i++) ld_w[i] = w;
      ld_b = b;
   endtask

   task automatic load_set();
      logic [7:0] wb;
      step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 16'h0000);
      for (int i = 0; i <= NT; i++) begin
         if (i == NT) wb = 8'(ld_b);
         else wb = 8'(ld_w[i]);
         step(1'b0, 1'b1, 1'b1, wb, 1'b0, 16'h0000);
      end
      step(1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 16'h0000);
   endtask

   // gap: 0 none, 1 alternate cycles, 2 random; rnd selects random pixels over constant cv
   task automatic run_frame(input int gap, input bit rnd, input int cv, input int n);
      int a;
      bit tog;
      bit idle_now;
      logic [15:0] px;
      a = 0;
      tog = 1'b0;
      while (a < n) begin
         idle_now = 1'b0;
         if (gap == 1) begin
            idle_now = tog;
            tog = !tog;
         end else if (gap == 2) begin
            idle_now = ($urandom_range(0, 2) == 0);
         end
         if (idle_now) begin
            step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 16'h0000);
         end else begin
            if (rnd) px = 16'($urandom);
            else px = pk(cv, cv);
            step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, px);
            a++;
         end
      end
   endtask

   // Monitor: per-cycle status checks and scoreboard pop on every conv_out_valid
   always @(negedge clk) begin : monitor
      int act;
      exp_t e;
      act = int'($signed(conv_out));
      if (tb_done) begin
         chk("pending_results", exp_q.size(), 0);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end else begin
         chk("frame_done", frame_done, fd_exp);
         chk("weights_ready", weights_ready, m_ready);
         if (chk_zero) begin
            chk("rst_conv_out", conv_out, 0);
            chk("rst_conv_out_valid", conv_out_valid, 0);
            chk("rst_conv_out_last", conv_out_last, 0);
         end
         if (conv_out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got conv_out=%0d at cycle %0d, expected no output", act, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("conv_out", act, e.val);
               chk("conv_out_last", conv_out_last, e.last);
               chk("output_cycle", cyc, e.cyc);
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_output: got no conv_out_valid at cycle %0d, expected value %0d", cyc, e.val);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; load_weight = 1'b0; weight_valid = 1'b0; weight_in = '0;
      pixel_valid = 1'b0; pixels_in = '0; relu_en = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 16'h0000);
      // no weights yet: pixels dropped
      repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, pk(7, 7));

      // all ones, back-to-back then alternate-cycle gaps
      set_w_all(1, 0);
      load_set();
      run_frame(0, 1'b0, 1, 25);
      idle(4);
      run_frame(1, 1'b0, 1, 25);
      idle(4);

      // signed weight, with and without ReLU
      set_w_all(0, 0);
      ld_w[4] = -1;
      load_set();
      run_frame(0, 1'b0, 5, 25);
      idle(4);
      relu_en = 1'b1;
      run_frame(0, 1'b0, 5, 25);
      idle(4);
      relu_en = 1'b0;

      // extremes
      set_w_all(-128, -128);
      load_set();
      run_frame(0, 1'b0, 255, 25);
      idle(4);

      // load abort after 15 accepts, then a full frame
      set_w_all(1, 0);
      load_set();
      run_frame(0, 1'b0, 1, 15);
      load_set();
      run_frame(0, 1'b0, 1, 25);
      idle(4);

      // reset mid-frame, dropped pixels, reload, full frame
      run_frame(0, 1'b1, 0, 14);
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 16'h0000);
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, pk(9, 9));
      load_set();
      run_frame(0, 1'b0, 1, 25);
      idle(4);

      // randomized weights, bias, pixels, gaps and ReLU; two frames back-to-back
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < NT; i++) ld_w[i] = $signed(8'($urandom_range(0, 255)));
         ld_b = $signed(8'($urandom_range(0, 255)));
         relu_en = 1'($urandom_range(0, 1));
         load_set();
         run_frame(2, 1'b1, 0, 2*W*H);
         idle(4);
      end

      idle(6);
      tb_done = 1'b1;
      repeat (4) @(posedge clk);
   end

endmodule
